// File: rtl/video_timing_gen.sv
// video_timing_gen : parametrised raster timing with double-buffered image-window request.
// Rev 1.0
`default_nettype none

module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12,
  parameter int WIN_X0   = 0,
  parameter int WIN_Y0   = 0,
  parameter int WIN_W0   = 225,
  parameter int WIN_H0   = 225
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [CW-1:0] win_x_i,
  input  logic [CW-1:0] win_y_i,
  input  logic [CW-1:0] win_w_i,
  input  logic [CW-1:0] win_h_i,
  output logic          hs_o,
  output logic          vs_o,
  output logic          de_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          win_req_o,
  output logic          win_first_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [CW-1:0] sx_q, sy_q, sw_q, sh_q;
  logic          seen_q, seen_d;

  logic h_last, v_last, origin, shadow_ld;
  logic de_d, hs_d, vs_d, win_hit, first_d, seen_eff;
  logic in_x, in_y;
  logic [CW:0] x_end, y_end;

  assign h_last    = (h_cnt_q == H_LAST);
  assign v_last    = (v_cnt_q == V_LAST);
  assign origin    = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign shadow_ld = en_i && h_last && v_last;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en_i) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  assign de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
  assign vs_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;

  // Window bounds are evaluated one bit wider so x+w never wraps.
  assign x_end   = {1'b0, sx_q} + {1'b0, sw_q};
  assign y_end   = {1'b0, sy_q} + {1'b0, sh_q};
  assign in_x    = ({1'b0, h_cnt_q} >= {1'b0, sx_q}) && ({1'b0, h_cnt_q} < x_end);
  assign in_y    = ({1'b0, v_cnt_q} >= {1'b0, sy_q}) && ({1'b0, v_cnt_q} < y_end);
  assign win_hit = de_d && in_x && in_y;

  // The "already requested this frame" flag is discarded at pixel (0,0).
  assign seen_eff = seen_q && !origin;
  assign first_d  = win_hit && !seen_eff;
  assign seen_d   = en_i ? (seen_eff || win_hit) : seen_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      sx_q          <= CW'(WIN_X0);
      sy_q          <= CW'(WIN_Y0);
      sw_q          <= CW'(WIN_W0);
      sh_q          <= CW'(WIN_H0);
      seen_q        <= 1'b0;
      hs_o          <= ~HS_POL;
      vs_o          <= ~VS_POL;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      win_req_o     <= 1'b0;
      win_first_o   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      seen_q  <= seen_d;
      if (shadow_ld) begin
        sx_q <= win_x_i;
        sy_q <= win_y_i;
        sw_q <= win_w_i;
        sh_q <= win_h_i;
      end
      if (en_i) begin
        hs_o          <= hs_d;
        vs_o          <= vs_d;
        de_o          <= de_d;
        x_o           <= de_d ? h_cnt_q : '0;
        y_o           <= de_d ? v_cnt_q : '0;
        line_start_o  <= de_d && (h_cnt_q == '0);
        frame_start_o <= origin;
        win_req_o     <= win_hit;
        win_first_o   <= first_d;
      end else begin
        hs_o          <= ~HS_POL;
        vs_o          <= ~VS_POL;
        de_o          <= 1'b0;
        x_o           <= '0;
        y_o           <= '0;
        line_start_o  <= 1'b0;
        frame_start_o <= 1'b0;
        win_req_o     <= 1'b0;
        win_first_o   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the HDMI/DVI output path; replaces fixed 640x480 hard-coded counters.
- Produces hs/vs/de, pixel coordinates, line/frame strobes and a programmable image-window request that paces a pixel source (image loader).
- Window config is double-buffered and only takes effect at frame boundaries, so the window can move without tearing.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 12, counter/coordinate width
- WIN_X0 / WIN_Y0 / WIN_W0 / WIN_H0, 0/0/225/225, reset window config

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset, asynchronous, active-high
- en_i  in  1  run enable
- win_x_i  in  CW  window left column
- win_y_i  in  CW  window top line
- win_w_i  in  CW  window width
- win_h_i  in  CW  window height
- hs_o  out  1  horizontal sync
- vs_o  out  1  vertical sync
- de_o  out  1  active video
- x_o  out  CW  active column (0 outside active)
- y_o  out  CW  active line (0 outside active)
- line_start_o  out  1  1-cycle pulse, first active pixel of each line
- frame_start_o  out  1  1-cycle pulse, pixel (0,0)
- win_req_o  out  1  pixel request inside the window
- win_first_o  out  1  1-cycle pulse, first window pixel of the frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments only when h_cnt wraps, and wraps at V_TOTAL-1.
- Reset:
  - h_cnt = v_cnt = 0.
  - Shadow window = WIN_*0.
  - All outputs registered. Reset values: de_o, win_req_o and all pulses = 0; x_o = y_o = 0; hs_o = !HS_POL; vs_o = !VS_POL.
- Latency: every output is a registered decode of (h_cnt, v_cnt). Outputs at cycle t+1 describe the counter state at cycle t.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync asserted (= HS_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
- vsync asserted (= VS_POL) for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, with whole-line granularity.
- x_o = h_cnt and y_o = v_cnt when de; otherwise 0.
- line_start = de && h_cnt == 0. frame_start = (h_cnt, v_cnt) == (0, 0).
- Window request: win_req = de && sx <= h_cnt < sx+sw && sy <= v_cnt < sy+sh, where sx/sy/sw/sh are the shadow copies. Comparisons use CW+1 bits so no sum wraps.
- Window edge cases:
  - Window extending past the active region is clipped by de.
  - sw == 0 or sh == 0 yields no requests.
  - win_first is the first win_req of each frame.
- Shadow load: win_*_i are sampled into the shadow on the cycle h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1 with en_i = 1. Changes at any other time have no effect until the next frame.
- en_i = 0:
  - Counters and shadow hold.
  - Next-cycle outputs forced to the inactive/reset values listed above.
  - On re-enable, counting resumes from the held position. Outputs become valid one cycle later, and no pulse is duplicated.
- Reset asserted mid-frame: immediate asynchronous return to reset state. After release, the first valid cycle is (0,0) and frame_start_o pulses one cycle later.

Test Plan:
- Default params, en_i = 1, 2 frames:
  - de_o high exactly 640 cycles per line, 480 lines per frame; 307200 de cycles per frame.
  - Frame period 420000 cycles.
  - hs_o low on h_cnt 656..751; vs_o low on lines 490..491.
- Default window (0,0,225,225):
  - 50625 win_req_o cycles per frame.
  - win_first_o pulses once, coincident with frame_start_o.
  - Request rows 0..224, columns 0..224.
- Window change: write (600,470,100,50) mid-frame.
  - Current frame keeps the old window.
  - Next frame requests only x 600..639, y 470..479: 400 cycles.
- win_w_i = 0: zero win_req_o and no win_first_o after the next boundary. de_o unchanged.
- en_i low for 37 cycles mid-line:
  - All outputs inactive during the gap.
  - After resume the line still carries 640 de cycles total; frame_start_o period grows by 37.
- HS_POL = VS_POL = 1 with small timing (H 8/2/2/2, V 4/1/1/1):
  - Sync levels inverted; hs_o high at h_cnt 10..11.
  - rst_i pulsed at h_cnt = 5, v_cnt = 2 → outputs at reset values immediately; frame_start_o one cycle after release.
